// File: rtl/round_pack_float64_if.sv
`default_nettype none
// ============================================================================
// Module   : round_pack_float64_if
// Brief    : ap_ctrl_hs handshake plus operand/result bundle for the
//            float64 round-and-pack stage.
// Revision : 1.0 - initial release
// ============================================================================
interface round_pack_float64_if #(
  parameter int SIG_W = 64,
  parameter int EXP_W = 12
);
  logic             ap_start;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_ready;
  logic             zSign;
  logic [EXP_W-1:0] zExp;
  logic [SIG_W-1:0] zSig;
  logic             flags_clr;
  logic [63:0]      working_key;
  logic [63:0]      ap_return;
  logic [4:0]       exc_flags;

  modport master (
    output ap_start, zSign, zExp, zSig, flags_clr, working_key,
    input  ap_done, ap_idle, ap_ready, ap_return, exc_flags
  );

  modport slave (
    input  ap_start, zSign, zExp, zSig, flags_clr, working_key,
    output ap_done, ap_idle, ap_ready, ap_return, exc_flags
  );
endinterface
`default_nettype wire

// File: rtl/round_pack_float64.sv
`default_nettype none
// ============================================================================
// Module   : round_pack_float64
// Brief    : Round-to-nearest-even and pack {sign, exp, sig} into IEEE-754
//            binary64, with overflow, subnormal jamming shift and sticky flags.
// Revision : 1.0 - initial release
// ============================================================================
module round_pack_float64 #(
  parameter int SIG_W     = 64,
  parameter int EXP_W     = 12,
  parameter int SHIFT_MAX = 64
) (
  input  wire logic             ap_clk,
  input  wire logic             ap_rst,
  round_pack_float64_if.slave   bus
);

  localparam int                      c_RSIG_W    = SIG_W - 9;
  localparam logic signed [EXP_W-1:0] c_EXP_OVF   = EXP_W'(2045);
  localparam logic [EXP_W-1:0]        c_SHIFT_MAX = EXP_W'(SHIFT_MAX);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_CHECK = 5'b00010,
    S_SHIFT = 5'b00100,
    S_ROUND = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t                   r_state;
  logic                     r_sign;
  logic signed [EXP_W-1:0]  r_exp;
  logic [SIG_W-1:0]         r_sig;
  logic [EXP_W-1:0]         r_cnt;
  logic                     r_tiny;
  logic                     r_ovf;
  logic                     r_done;
  logic [63:0]              r_ret;
  logic [4:0]               r_flags;

  logic [3:0]               w_key;
  logic [9:0]               w_rb;
  logic                     w_tie;
  logic                     w_inexact;
  logic [SIG_W:0]           w_sum;
  logic [c_RSIG_W-1:0]      w_rsig_raw;
  logic [c_RSIG_W-1:0]      w_rsig;
  logic [EXP_W-1:0]         w_rexp;
  logic [63:0]              w_packed;
  logic [63:0]              w_inf;
  logic                     w_ovf;
  logic [SIG_W-1:0]         w_sig_shr;
  logic [4:0]               w_new_flags;
  logic [63:0]              w_new_ret;

  assign w_key      = bus.working_key[3:0];

  // Rounding datapath: a 65-bit sum keeps the carry out of bit 63 visible.
  assign w_rb       = r_sig[9:0];
  assign w_tie      = (w_rb == 10'h200);
  assign w_inexact  = |w_rb;
  assign w_sum      = {1'b0, r_sig} + {{(SIG_W-9){1'b0}}, 10'h200};
  assign w_rsig_raw = w_sum[SIG_W:10];
  assign w_rsig     = w_rsig_raw & ~{{(c_RSIG_W-1){1'b0}}, w_tie};
  assign w_rexp     = (w_rsig == '0) ? '0 : r_exp;
  assign w_packed   = {r_sign, 63'b0} + {w_rexp, 52'b0}
                    + {{(64-c_RSIG_W){1'b0}}, w_rsig};
  assign w_inf      = {r_sign, 11'h7FF, 52'b0};

  assign w_ovf      = (r_exp > c_EXP_OVF) ||
                      ((r_exp == c_EXP_OVF) && w_sum[SIG_W-1]);

  // One-bit jamming shift: the bit falling off is folded back into bit 0.
  assign w_sig_shr  = {1'b0, r_sig[SIG_W-1:1]} | {{(SIG_W-1){1'b0}}, r_sig[0]};

  assign w_new_flags = r_ovf ? 5'b00101
                             : {2'b00, 1'b0, r_tiny & w_inexact, w_inexact};
  assign w_new_ret   = r_ovf ? w_inf : w_packed;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_sig   <= '0;
      r_cnt   <= '0;
      r_tiny  <= 1'b0;
      r_ovf   <= 1'b0;
      r_done  <= 1'b0;
      r_ret   <= '0;
      r_flags <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.flags_clr) begin
        r_flags <= '0;
      end

      unique case (r_state)
        S_IDLE: begin
          if (bus.ap_start) begin
            r_sign  <= bus.zSign;
            r_exp   <= bus.zExp;
            r_sig   <= bus.zSig;
            r_tiny  <= 1'b0;
            r_ovf   <= 1'b0;
            r_state <= w_key[0] ? S_ROUND : S_CHECK;
          end
        end

        S_CHECK: begin
          if (w_key[1]) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (w_ovf) begin
            r_ovf   <= 1'b1;
            r_state <= S_ROUND;
          end else if (r_exp[EXP_W-1]) begin
            r_cnt   <= EXP_W'(-r_exp);
            r_state <= S_SHIFT;
          end else begin
            r_state <= S_ROUND;
          end
        end

        S_SHIFT: begin
          if (w_key[2]) begin
            r_state <= S_ROUND;
          end else if (r_cnt >= c_SHIFT_MAX) begin
            r_sig   <= {{(SIG_W-1){1'b0}}, |r_sig};
            r_exp   <= '0;
            r_tiny  <= 1'b1;
            r_state <= S_ROUND;
          end else begin
            r_sig <= w_sig_shr;
            r_cnt <= r_cnt - EXP_W'(1);
            // cnt <= 1 also catches a zero count so the state can never stall.
            if (r_cnt <= EXP_W'(1)) begin
              r_exp   <= '0;
              r_tiny  <= 1'b1;
              r_state <= S_ROUND;
            end
          end
        end

        S_ROUND: begin
          if (w_key[3]) begin
            r_state <= S_IDLE;
          end else begin
            r_ret   <= w_new_ret;
            r_flags <= bus.flags_clr ? w_new_flags : (r_flags | w_new_flags);
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ap_done   = r_done;
  assign bus.ap_ready  = r_done;
  assign bus.ap_idle   = (r_state == S_IDLE) && !bus.ap_start;
  assign bus.ap_return = r_ret;
  assign bus.exc_flags = r_flags;

endmodule
`default_nettype wire
